// File: rtl/dm_pkg.sv
// Shared constants and FSM encoding for the data-memory arbiter.
// Sizes match the data memory (DMSIZE=8, DM_MAX=128).
package dm_pkg;

  localparam int DM_AW         = 8;
  localparam int DM_DW         = 32;
  localparam int DM_DEPTH      = 128;
  localparam int DM_LD_WORDS   = 2;
  localparam int DM_MIRROR_OFF = 4;
  localparam int DM_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    BOOT_P,
    BOOT_M,
    IDLE,
    RD_WAIT
  } dm_state_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Pipeline, loader and memory port bundle of the data-memory arbiter.
// slave = arbiter side, master = requesters and memory side.
interface dm_arbiter_if
  import dm_pkg::*;
#(
  parameter int AW = DM_AW,
  parameter int DW = DM_DW
);

  logic          pipe_req;
  logic          pipe_we;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_wdata;
  logic          pipe_stall;
  logic          pipe_rvalid;
  logic [DW-1:0] pipe_rdata;

  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_done;

  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;

  logic          err_oob;

  modport slave (
    input  pipe_req, pipe_we,
    input  pipe_addr, pipe_wdata,
    output pipe_stall, pipe_rvalid,
    output pipe_rdata,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready, ld_done,
    output dm_we, dm_addr, dm_wdata,
    input  dm_rdata,
    output err_oob
  );

  modport master (
    output pipe_req, pipe_we,
    output pipe_addr, pipe_wdata,
    input  pipe_stall, pipe_rvalid,
    input  pipe_rdata,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready, ld_done,
    input  dm_we, dm_addr, dm_wdata,
    output dm_rdata,
    input  err_oob
  );

endinterface

// File: rtl/dm_boot_seq.sv
// Boot fill sequencer: primary/mirror address generation,
// zero-word suppression and the sticky ld_done flag.
module dm_boot_seq
  import dm_pkg::*;
#(
  parameter int AW         = DM_AW,
  parameter int DW         = DM_DW,
  parameter int LD_WORDS   = DM_LD_WORDS,
  parameter int MIRROR_OFF = DM_MIRROR_OFF
) (
  input  logic          clk,
  input  logic          rst2,
  input  logic          in_prim,
  input  logic          in_mirr,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          wr_req,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          last,
  output logic          ld_done
);

  localparam int CW = $clog2(LD_WORDS + 1);

  logic [CW-1:0] cnt;
  logic [DW-1:0] word;

  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      cnt     <= '0;
      word    <= '0;
      ld_done <= 1'b0;
    end else begin
      if (in_prim && ld_valid)
        word <= ld_data;
      if (in_mirr) begin
        cnt <= cnt + 1'b1;
        if (last)
          ld_done <= 1'b1;
      end
    end
  end

  assign last = (cnt == CW'(LD_WORDS - 1));

  // A zero word only lands in its mirror slot.
  assign wr_req = in_mirr
                | (in_prim & ld_valid & (|ld_data));

  assign wr_addr = in_mirr
                 ? AW'(cnt) + AW'(MIRROR_OFF)
                 : AW'(cnt);

  assign wr_data = in_mirr ? word : ld_data;

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter between MEM stage and loader.
// DM_ARB_RR_EN selects round-robin conflict arbitration.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int AW         = DM_AW,
  parameter int DW         = DM_DW,
  parameter int DEPTH      = DM_DEPTH,
  parameter int LD_WORDS   = DM_LD_WORDS,
  parameter int MIRROR_OFF = DM_MIRROR_OFF,
  parameter int STARVE_MAX = DM_STARVE_MAX
) (
  input logic         clk,
  input logic         rst2,
  dm_arbiter_if.slave bus
);

  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  dm_state_e state, nxt;

  logic          p_oob, l_oob;
  logic          ld_win, pipe_win;
  logic          rd_oob;
  logic          b_req, b_last, b_done;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;

  assign p_oob = {1'b0, bus.pipe_addr} >= LIM;
  assign l_oob = {1'b0, bus.ld_addr} >= LIM;

`ifdef DM_ARB_RR_EN
  logic last_pipe;

  assign ld_win = bus.ld_valid
                & (~bus.pipe_req | last_pipe);

  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2)
      last_pipe <= 1'b0;
    else if (state == IDLE && bus.pipe_req
             && bus.ld_valid)
      last_pipe <= ~ld_win;
  end
`else
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  assign ld_win = bus.ld_valid
                & (~bus.pipe_req
                   | (starve_cnt == SW'(STARVE_MAX)));

  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2)
      starve_cnt <= '0;
    else if (state == IDLE) begin
      if (ld_win)
        starve_cnt <= '0;
      else if (bus.ld_valid)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  assign pipe_win = bus.pipe_req & ~ld_win;

  dm_boot_seq #(
    .AW         (AW),
    .DW         (DW),
    .LD_WORDS   (LD_WORDS),
    .MIRROR_OFF (MIRROR_OFF)
  ) u_boot (
    .clk      (clk),
    .rst2     (rst2),
    .in_prim  (state == BOOT_P),
    .in_mirr  (state == BOOT_M),
    .ld_valid (bus.ld_valid),
    .ld_data  (bus.ld_data),
    .wr_req   (b_req),
    .wr_addr  (b_addr),
    .wr_data  (b_data),
    .last     (b_last),
    .ld_done  (b_done)
  );

  assign bus.ld_done = b_done;

  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      state  <= BOOT_P;
      rd_oob <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && pipe_win
          && !bus.pipe_we)
        rd_oob <= p_oob;
    end
  end

  always_comb begin
    nxt             = state;
    bus.pipe_stall  = 1'b0;
    bus.pipe_rvalid = 1'b0;
    bus.pipe_rdata  = '0;
    bus.ld_ready    = 1'b0;
    bus.dm_we       = 1'b0;
    bus.dm_addr     = '0;
    bus.dm_wdata    = '0;
    bus.err_oob     = 1'b0;
    unique case (state)
      BOOT_P: begin
        bus.ld_ready   = 1'b1;
        bus.pipe_stall = bus.pipe_req;
        bus.dm_we      = b_req;
        bus.dm_addr    = b_addr;
        bus.dm_wdata   = b_data;
        if (bus.ld_valid)
          nxt = BOOT_M;
      end
      BOOT_M: begin
        bus.pipe_stall = bus.pipe_req;
        bus.dm_we      = b_req;
        bus.dm_addr    = b_addr;
        bus.dm_wdata   = b_data;
        nxt = b_last ? IDLE : BOOT_P;
      end
      IDLE: begin
        if (pipe_win) begin
          if (p_oob) begin
            bus.err_oob = 1'b1;
            if (!bus.pipe_we)
              nxt = RD_WAIT;
          end else if (bus.pipe_we) begin
            bus.dm_we    = 1'b1;
            bus.dm_addr  = bus.pipe_addr;
            bus.dm_wdata = bus.pipe_wdata;
          end else begin
            bus.dm_addr    = bus.pipe_addr;
            bus.pipe_stall = 1'b1;
            nxt            = RD_WAIT;
          end
        end else if (bus.pipe_req) begin
          bus.pipe_stall = 1'b1;
        end
        if (ld_win) begin
          bus.ld_ready = 1'b1;
          if (l_oob) begin
            bus.err_oob = 1'b1;
          end else begin
            bus.dm_we    = 1'b1;
            bus.dm_addr  = bus.ld_addr;
            bus.dm_wdata = bus.ld_data;
          end
        end
      end
      RD_WAIT: begin
        bus.pipe_rvalid = 1'b1;
        bus.pipe_rdata  = rd_oob ? '0 : bus.dm_rdata;
        nxt             = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed and random checks of dm_arbiter against a
// transaction-level model with a shadow of memory contents.
module tb_dm_arbiter;

  localparam int LD  = 2;
  localparam int MIR = 4;
  localparam int SMX = 4;

  logic clk = 1'b0;
  logic rst2 = 1'b0;

  dm_arbiter_if #(.AW(8), .DW(32)) bus ();

  dm_arbiter dut (
    .clk  (clk),
    .rst2 (rst2),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory with a registered read address.
  logic [31:0] mem [256];
  logic [7:0]  raddr;

  always @(posedge clk) begin
    if (bus.dm_we)
      mem[bus.dm_addr] <= bus.dm_wdata;
    raddr <= bus.dm_addr;
  end

  assign bus.dm_rdata = mem[raddr];

  int vec  = 0;
  int errs = 0;

  // Model state
  logic [31:0] shadow [256];
  int          m_boot;
  bit          m_mir;
  logic [31:0] m_word;
  bit          m_pend;
  logic [31:0] m_rval;
  int          m_starve;
  bit          m_lastp;

  // Handshake results and samples of the last step
  bit          p_acc, l_acc, quiet;
  logic        s_stall, s_rv, s_rdy;
  logic        s_err, s_we, s_done;
  logic [31:0] s_rd;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot   = 0;
    m_mir    = 0;
    m_word   = '0;
    m_pend   = 0;
    m_rval   = '0;
    m_starve = 0;
    m_lastp  = 0;
    quiet    = 0;
  endtask

  task automatic idle_inputs();
    bus.pipe_req   = 0;
    bus.pipe_we    = 0;
    bus.pipe_addr  = '0;
    bus.pipe_wdata = '0;
    bus.ld_valid   = 0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
  endtask

  task automatic do_reset();
    rst2 = 0;
    idle_inputs();
    @(negedge clk);
    chk("rst_ld_ready", 32'(bus.ld_ready), 1);
    chk("rst_stall", 32'(bus.pipe_stall), 0);
    chk("rst_rvalid", 32'(bus.pipe_rvalid), 0);
    chk("rst_ld_done", 32'(bus.ld_done), 0);
    chk("rst_dm_we", 32'(bus.dm_we), 0);
    chk("rst_err", 32'(bus.err_oob), 0);
    @(posedge clk);
    #1 rst2 = 1;
    model_reset();
  endtask

  task automatic step();
    bit          e_stall, e_rv, e_rdy, e_err;
    bit          e_we, chk_rdy, boot, lw, pw;
    bit          poob, loob, ld_ok;
    logic [31:0] e_rd, e_wd;
    logic [7:0]  e_wa;
    e_stall = 0; e_rv = 0; e_rdy = 0;
    e_err = 0; e_we = 0; chk_rdy = 0;
    lw = 0; pw = 0;
    e_rd = '0; e_wd = '0; e_wa = '0;
    @(negedge clk);
    boot = m_boot < LD;
    poob = bus.pipe_addr >= 8'd128;
    loob = bus.ld_addr >= 8'd128;
    if (boot) begin
      e_stall = bus.pipe_req;
      chk_rdy = bus.ld_valid;
      if (!m_mir) begin
        e_rdy = 1;
        chk_rdy = 1;
        if (bus.ld_valid && bus.ld_data != 0) begin
          e_we = 1;
          e_wa = 8'(m_boot);
          e_wd = bus.ld_data;
        end
      end else begin
        e_we = 1;
        e_wa = 8'(m_boot + MIR);
        e_wd = m_word;
      end
    end else if (m_pend) begin
      e_rv = 1;
      e_rd = m_rval;
      chk_rdy = bus.ld_valid;
    end else begin
`ifdef DM_ARB_RR_EN
      ld_ok = m_lastp;
`else
      ld_ok = (m_starve == SMX);
`endif
      lw = bus.ld_valid && (!bus.pipe_req || ld_ok);
      pw = bus.pipe_req && !lw;
      e_stall = bus.pipe_req && !pw;
      chk_rdy = bus.ld_valid;
      if (pw) begin
        if (poob) e_err = 1;
        else if (bus.pipe_we) begin
          e_we = 1;
          e_wa = bus.pipe_addr;
          e_wd = bus.pipe_wdata;
        end else e_stall = 1;
      end
      if (lw) begin
        e_rdy = 1;
        if (loob) e_err = 1;
        else begin
          e_we = 1;
          e_wa = bus.ld_addr;
          e_wd = bus.ld_data;
        end
      end
    end
    s_stall = bus.pipe_stall;
    s_rv    = bus.pipe_rvalid;
    s_rd    = bus.pipe_rdata;
    s_rdy   = bus.ld_ready;
    s_err   = bus.err_oob;
    s_we    = bus.dm_we;
    s_done  = bus.ld_done;
    chk("stall", 32'(s_stall), 32'(e_stall));
    chk("rvalid", 32'(s_rv), 32'(e_rv));
    if (e_rv) chk("rdata", s_rd, e_rd);
    if (chk_rdy) chk("ld_ready", 32'(s_rdy), 32'(e_rdy));
    chk("err_oob", 32'(s_err), 32'(e_err));
    chk("dm_we", 32'(s_we), 32'(e_we));
    if (e_we) begin
      chk("dm_addr", 32'(bus.dm_addr), 32'(e_wa));
      chk("dm_wdata", bus.dm_wdata, e_wd);
    end
    chk("ld_done", 32'(s_done), 32'(m_boot == LD));
    p_acc = bus.pipe_req && !e_stall;
    l_acc = bus.ld_valid && e_rdy;
    quiet = pw && !bus.pipe_we && poob;
    @(posedge clk);
    if (boot) begin
      if (!m_mir && bus.ld_valid) begin
        m_mir  = 1;
        m_word = bus.ld_data;
      end else if (m_mir) begin
        m_mir = 0;
        m_boot++;
      end
    end else if (m_pend) begin
      m_pend = 0;
    end else begin
      if (lw) m_starve = 0;
      else if (bus.ld_valid) m_starve++;
      if (bus.pipe_req && bus.ld_valid)
        m_lastp = pw;
      if (pw && !bus.pipe_we) begin
        m_pend = 1;
        m_rval = poob ? '0 : shadow[bus.pipe_addr];
      end
    end
    if (e_we) shadow[e_wa] = e_wd;
    #1;
  endtask

  task automatic boot2(input logic [31:0] a,
                       input logic [31:0] b);
    bus.ld_valid = 1; bus.ld_data = a; step();
    bus.ld_valid = 0; step();
    bus.ld_valid = 1; bus.ld_data = b; step();
    bus.ld_valid = 0; step();
  endtask

  initial begin
    int  n;
    bit  got, p_hold, l_hold;
    idle_inputs();
    model_reset();
    do_reset();

    boot2(32'd5, 32'd7);
    chk("boot_done", 32'(bus.ld_done), 1);
    chk("mem0", mem[0], 32'd5);
    chk("mem4", mem[4], 32'd5);
    chk("mem1", mem[1], 32'd7);
    chk("mem5", mem[5], 32'd7);

    do_reset();
    boot2(32'd0, 32'd9);
    chk("zero_mem0", mem[0], 32'd5);
    chk("zero_mem4", mem[4], 32'd0);
    chk("zero_mem1", mem[1], 32'd9);
    chk("zero_mem5", mem[5], 32'd9);

    bus.pipe_req = 1; bus.pipe_we = 1;
    bus.pipe_addr = 8'd10;
    bus.pipe_wdata = 32'h1234;
    step();
    chk("sw_stall", 32'(s_stall), 0);
    bus.pipe_we = 0;
    step();
    chk("lw_stall", 32'(s_stall), 1);
    step();
    chk("lw_rvalid", 32'(s_rv), 1);
    chk("lw_rdata", s_rd, 32'h1234);
    bus.pipe_req = 0;
    step();

    bus.pipe_req = 1; bus.pipe_we = 1;
    bus.pipe_addr = 8'd20;
    bus.ld_valid = 1; bus.ld_addr = 8'd30;
    bus.ld_data = 32'd77;
    n = 0; got = 0;
    for (int k = 1; k <= 8 && !got; k++) begin
      bus.pipe_wdata = 32'(k);
      step();
      if (s_rdy) begin got = 1; n = k; end
    end
`ifdef DM_ARB_RR_EN
    chk("rr_grant", 32'(n), 32'd2);
`else
    chk("starve_grant", 32'(n), 32'd5);
`endif
    idle_inputs();
    step();

    bus.pipe_req = 1; bus.pipe_we = 0;
    bus.pipe_addr = 8'd200;
    step();
    chk("oob_err", 32'(s_err), 1);
    chk("oob_stall", 32'(s_stall), 0);
    chk("oob_we", 32'(s_we), 0);
    bus.pipe_req = 0;
    step();
    chk("oob_rvalid", 32'(s_rv), 1);
    chk("oob_rdata", s_rd, 32'd0);

    bus.pipe_req = 1; bus.pipe_addr = 8'd3;
    step();
    bus.pipe_req = 0;
    rst2 = 0;
    #1;
    chk("mid_rvalid", 32'(bus.pipe_rvalid), 0);
    chk("mid_done", 32'(bus.ld_done), 0);
    chk("mid_ready", 32'(bus.ld_ready), 1);
    do_reset();

    p_hold = 0; l_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!p_hold) begin
        if (quiet) bus.pipe_req = 0;
        else begin
          bus.pipe_req = ($urandom_range(0, 1) == 1);
          bus.pipe_we = ($urandom_range(0, 1) == 1);
          bus.pipe_addr = ($urandom_range(0, 9) == 0)
            ? 8'($urandom_range(128, 255))
            : 8'($urandom_range(0, 15));
          bus.pipe_wdata = $urandom;
        end
      end
      if (!l_hold) begin
        bus.ld_valid = ($urandom_range(0, 2) == 0);
        bus.ld_addr = ($urandom_range(0, 9) == 0)
          ? 8'($urandom_range(128, 255))
          : 8'($urandom_range(0, 15));
        bus.ld_data = ($urandom_range(0, 3) == 0)
          ? 32'd0 : $urandom;
      end
      step();
      p_hold = bus.pipe_req && !p_acc;
      l_hold = bus.ld_valid && !l_acc;
      if (i == 700) begin
        do_reset();
        p_hold = 0; l_hold = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Sequencer and arbiter for the single-port data memory in the pipelined MIPS core. It owns the memory's only write/address port and shares it between the MEM-stage load/store path and the memory loader port. The loader port fills initial data words, each mirrored at a fixed offset, during boot and may issue runtime writes afterwards. The block stalls the pipeline whenever the memory is busy and handles the memory's one-cycle registered-address read latency.

## Interface
- AW, 8: memory address width.
- DW, 32: data width.
- DEPTH, 128: number of valid memory words; addresses ≥ DEPTH are out of range.
- LD_WORDS, 2: words written during boot.
- MIRROR_OFF, 4: offset of each boot word's mirror copy.
- STARVE_MAX, 4: loader wait cycles before it pre-empts the pipeline (fixed-priority mode only).

Ports:
- clk  in  1  sole clock, rising edge.
- rst2  in  1  reset, asynchronous, active-low.
- pipe_req  in  1  MEM stage access request; held until accepted.
- pipe_we  in  1  1 = store (sw), 0 = load (lw).
- pipe_addr  in  AW  word address.
- pipe_wdata  in  DW  store data.
- pipe_stall  out  1  pipeline must hold MEM stage this cycle.
- pipe_rvalid  out  1  one-cycle pulse: pipe_rdata valid.
- pipe_rdata  out  DW  load data.
- ld_valid  in  1  loader word offered.
- ld_addr  in  AW  runtime loader address; ignored during boot.
- ld_data  in  DW  loader data.
- ld_ready  out  1  loader word accepted this cycle when ld_valid=1.
- ld_done  out  1  boot fill complete; sticky until reset.
- dm_we  out  1  memory write enable.
- dm_addr  out  AW  memory address (write address; read address latched by memory).
- dm_wdata  out  DW  memory write data.
- dm_rdata  in  DW  memory read data, valid the cycle after the address is presented.
- err_oob  out  1  one-cycle pulse: out-of-range request dropped.

## Operation
- States:
  - BOOT_P: primary boot write.
  - BOOT_M: mirror write.
  - IDLE
  - RD_WAIT
- BOOT_P:
  - ld_ready=1.
  - On ld_valid: write ld_data to address boot_cnt, go to BOOT_M.
- BOOT_M:
  - Write the latched word to boot_cnt+MIRROR_OFF.
  - Increment boot_cnt.
  - If boot_cnt reaches LD_WORDS, set ld_done and go to IDLE; otherwise return to BOOT_P.
- Boot zero rule: a boot word equal to 0 is written only to its mirror; the primary write is suppressed (dm_we=0 in that BOOT_P cycle).
- During boot, pipe_stall=1 whenever pipe_req=1.
- IDLE, single requester:
  - Pipeline store: write in 1 cycle, pipe_stall=0.
  - Pipeline load: present address, pipe_stall=1, go to RD_WAIT.
  - Loader: write ld_data to ld_addr, ld_ready=1.
- RD_WAIT:
  - pipe_rdata=dm_rdata, pipe_rvalid=1, pipe_stall=0.
  - Return to IDLE.
  - No other grant this cycle.
- IDLE conflict (pipe_req and ld_valid together): the pipeline wins unless starve_cnt == STARVE_MAX.
  - starve_cnt increments on each cycle the loader loses, and clears on each loader grant.
  - The losing pipeline request sees pipe_stall=1.
- Out-of-range address (≥ DEPTH) from either port:
  - Request is accepted and consumed: no stall, ld_ready=1.
  - No memory write. A load returns 0 with pipe_rvalid next cycle.
  - err_oob pulses.
- dm_we is never asserted in RD_WAIT.

## Timing
- Reset values: state=BOOT_P, boot_cnt=0, starve_cnt=0, all outputs 0 except ld_ready=1.
- Store latency 1 cycle. Load latency 2 cycles: address cycle with stall, then data cycle with rvalid.
- Grants are combinational from registered state and current inputs; all state changes happen on the clk rising edge.
- Reset asserted mid-boot or mid-read aborts the operation immediately. A pending rvalid is not issued. Boot restarts at BOOT_P with boot_cnt=0.
- Memory contents are not cleared by reset.

## Configuration
- DM_ARB_RR_EN defined: on conflict, strict round-robin between the two ports.
  - One last_grant bit.
  - starve_cnt and STARVE_MAX are removed.
  - The first conflict after reset goes to the pipeline.
- Undefined: fixed pipeline priority with the starvation counter described above.

## Structure
- Shared package dm_pkg holds:
  - the state encoding (BOOT_P, BOOT_M, IDLE, RD_WAIT);
  - the AW, DW, DEPTH, MIRROR_OFF defaults, consistent with the memory's DMSIZE=8 and DM_MAX=128.
- One sub-module, dm_boot_seq: the boot counter, mirror-address generation and zero rule. It outputs a write request, address, data and ld_done.
- The arbiter FSM stays in dm_arbiter.

## Test plan
- Boot: ld_data 5 then 7 → writes mem[0]=5, mem[4]=5, mem[1]=7, mem[5]=7 over 4 cycles; ld_done rises after the fourth.
- Zero boot word: ld_data 0 then 9 → no write to address 0, mem[4]=0, mem[1]=9, mem[5]=9.
- After boot, sw 0x1234 to address 10, then lw address 10 → pipe_stall 1 cycle; pipe_rvalid with pipe_rdata=0x1234 on the second cycle.
- Continuous pipe_req with ld_valid held (fixed priority) → loader granted on the fifth conflicting cycle. With DM_ARB_RR_EN, grants alternate pipe, loader, pipe.
- lw address 200 → err_oob pulse, pipe_rvalid with 0 next cycle, no dm_we.
- rst2 low during RD_WAIT → no pipe_rvalid; state returns to BOOT_P and ld_done=0.
